// File: rtl/core_pkg.sv
// Shared core definitions: write-back load-type codes and performance
// counter selectors used by the MEM/WB segment.
package core_pkg;

  // Load-type / write code carried on reg_write_m / reg_write_w.
  typedef enum logic [2:0] {
    RW_NONE  = 3'd0,
    RW_WORD  = 3'd1,
    RW_HALF  = 3'd2,
    RW_HALFU = 3'd3,
    RW_BYTE  = 3'd4,
    RW_BYTEU = 3'd5,
    RW_ALU   = 3'd6
  } reg_write_e;

  // Performance counter selectors (cnt_sel values).
  localparam logic [1:0] CNT_RD_HIT  = 2'd0;
  localparam logic [1:0] CNT_RD_MISS = 2'd1;
  localparam logic [1:0] CNT_WR_HIT  = 2'd2;
  localparam logic [1:0] CNT_WR_MISS = 2'd3;

  // Classify an access; a read wins when read and write are both requested.
  function automatic logic [1:0] access_class(input logic is_read, input logic miss);
    if (is_read) return miss ? CNT_RD_MISS : CNT_RD_HIT;
    else         return miss ? CNT_WR_MISS : CNT_WR_HIT;
  endfunction

endpackage

// File: rtl/perf_counter_sat.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module perf_counter_sat #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Count up on inc, stick at all-ones, zero on clr.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   count <= '0;
    else if (clr)              count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB segment register with data-cache request drive, load-data hold
// across stalls, flush, and per-class saturating access counters.
module mem_wb_stage
  import core_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int BSEL_W  = $clog2(XLEN/8),
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clear,
  input  logic [XLEN-1:0]     addr_m,
  input  logic [XLEN-1:0]     wd_m,
  input  logic [XLEN/8-1:0]   we_m,
  input  logic                mem_to_reg_m,
  input  logic [XLEN-1:0]     result_m,
  input  logic [RADDR_W-1:0]  rd_m,
  input  logic [2:0]          reg_write_m,
  output logic [XLEN-1:0]     cache_addr,
  output logic                cache_rd_req,
  output logic                cache_wr_req,
  output logic [XLEN-1:0]     cache_wr_data,
  input  logic [XLEN-1:0]     cache_rd_data,
  input  logic                cache_miss,
  output logic                stall_req,
  output logic [XLEN-1:0]     rd_w,
  output logic [BSEL_W-1:0]   bsel_w,
  output logic [XLEN-1:0]     result_w,
  output logic [RADDR_W-1:0]  rdidx_w,
  output logic [2:0]          reg_write_w,
  output logic                mem_to_reg_w,
  input  logic [1:0]          cnt_sel,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    cnt_value
);

  logic            hold;
  logic [XLEN-1:0] held;
  logic            counted;
  logic            access_valid;
  logic            count_now;
  logic [1:0]      cls;
  logic [3:0]      cnt_inc;
  logic [CNT_W-1:0] cnt [4];

  // Cache requests come straight from memory-stage signals.
  assign cache_addr    = addr_m;
  assign cache_rd_req  = mem_to_reg_m;
  assign cache_wr_req  = |we_m;
  assign cache_wr_data = wd_m;
  assign access_valid  = cache_rd_req | cache_wr_req;
  assign stall_req     = cache_miss & access_valid;

  // Load data comes from the bus unless a stall froze it.
  assign rd_w = hold ? held : cache_rd_data;

  // Segment registers: flush on en&clear, advance on en, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bsel_w       <= '0;
      result_w     <= '0;
      rdidx_w      <= '0;
      reg_write_w  <= '0;
      mem_to_reg_w <= 1'b0;
    end else if (en) begin
      if (clear) begin
        bsel_w       <= '0;
        result_w     <= '0;
        rdidx_w      <= '0;
        reg_write_w  <= '0;
        mem_to_reg_w <= 1'b0;
      end else begin
        bsel_w       <= addr_m[BSEL_W-1:0];
        result_w     <= result_m;
        rdidx_w      <= rd_m;
        reg_write_w  <= reg_write_m;
        mem_to_reg_w <= mem_to_reg_m;
      end
    end
  end

  // Freeze load data on a hold edge; release it when the segment advances.
  // held re-captures rd_w, which is already held data after the first stall edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= 1'b0;
      held <= '0;
    end else if (en) begin
      hold <= 1'b0;
      held <= '0;
    end else begin
      hold <= 1'b1;
      held <= rd_w;
    end
  end

  // Count each access once per pipeline advance.
  assign count_now = access_valid & ~counted;
  assign cls       = access_class(cache_rd_req, cache_miss);

  // Remember that a stalled access has already been counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            counted <= 1'b0;
    else if (en)        counted <= 1'b0;
    else if (count_now) counted <= 1'b1;
  end

  // One saturating counter per access class.
  for (genvar i = 0; i < 4; i++) begin : g_cnt
    assign cnt_inc[i] = count_now && (cls == 2'(i));

    perf_counter_sat #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (cnt_inc[i]),
      .clr   (cnt_clr),
      .count (cnt[i])
    );
  end

  // Readout mux for the selected counter.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    cnt_value = '0;
    case (cnt_sel)
      CNT_RD_HIT:  cnt_value = cnt[0];
      CNT_RD_MISS: cnt_value = cnt[1];
      CNT_WR_HIT:  cnt_value = cnt[2];
      CNT_WR_MISS: cnt_value = cnt[3];
      default:     cnt_value = '0;
    endcase
  end

endmodule
